// File: rtl/sdram_req_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_req_fetch_if
//  Description : Bundle between the request-FIFO read port, the request
//                fetcher and the SDRAM command engine.
//                  FIFO side   : fifo_empty, fifo_rd_data, fifo_rd_enable
//                  Command     : cmd_valid/cmd_ready, cmd_we, cmd_addr, cmd_len
//                  Write data  : wdata_valid/wdata_ready, wdata, wdata_last
//                  Status      : hdr_err, req_count
//                master = request fetcher, slave = FIFO + command engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_req_fetch_if #(
    parameter int DWIDTH = 16,
    parameter int CNT_W  = 16
);
    // FIFO read port (first-word fall-through)
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_rd_data;
    logic              fifo_rd_enable;

    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [23:0]       cmd_addr;
    logic [3:0]        cmd_len;

    // Write-data channel
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DWIDTH-1:0] wdata;
    logic              wdata_last;

    // Status
    logic              hdr_err;
    logic [CNT_W-1:0]  req_count;

    modport master (
        input  fifo_empty, fifo_rd_data, cmd_ready, wdata_ready,
        output fifo_rd_enable, cmd_valid, cmd_we, cmd_addr, cmd_len,
               wdata_valid, wdata, wdata_last, hdr_err, req_count
    );

    modport slave (
        output fifo_empty, fifo_rd_data, cmd_ready, wdata_ready,
        input  fifo_rd_enable, cmd_valid, cmd_we, cmd_addr, cmd_len,
               wdata_valid, wdata, wdata_last, hdr_err, req_count
    );
endinterface
`default_nettype wire

// File: rtl/sdram_req_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_req_fetch
//  Description : Read-side consumer of the clock-crossing request FIFO.
//                Pops packed request words (FWFT FIFO), rebuilds one command
//                (direction, 24-bit word address, burst length 1..8) and a
//                stream of write-data beats, and hands both to the SDRAM
//                command engine over valid/ready handshakes.
//
//                Request words, in FIFO order:
//                  H0 = {we, len_m1[2:0], addr[23:12]}
//                  H1 = {rsvd[3:0], addr[11:0]}
//                  len_m1+1 data words follow when we=1.
//
//  Ports       : clk  - controller clock
//                rst  - asynchronous reset, active-high
//                bus  - sdram_req_fetch_if.master (FIFO read port, command
//                       channel, write-data channel, hdr_err, req_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_req_fetch #(
    parameter int DWIDTH = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_req_fetch_if.master     bus
);

    // The packed request format is only defined for 16-bit FIFO words.
    if (DWIDTH != 16) begin : g_bad_dwidth
        $fatal(1, "sdram_req_fetch: DWIDTH must be 16");
    end

    typedef enum logic [1:0] {
        S_HDR0  = 2'd0,
        S_HDR1  = 2'd1,
        S_CMD   = 2'd2,
        S_WDATA = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_cmd_we;
    logic [23:0]       r_cmd_addr;
    logic [3:0]        r_cmd_len;
    logic [2:0]        r_beat_cnt;
    logic [CNT_W-1:0]  r_req_count;
    logic              r_hdr_err;

    logic              w_pop;
    logic              w_cmd_valid;
    logic              w_wdata_valid;
    logic              w_wdata_last;
    logic              w_req_done;

    // ------------------------------------------------------------------------
    // Next-state and handshake decode. Every pop is qualified by ~fifo_empty
    // so the FIFO can never be underflowed, whatever state we are in.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_cmd_valid   = 1'b0;
        w_wdata_valid = 1'b0;
        w_wdata_last  = 1'b0;
        w_req_done    = 1'b0;

        case (r_state)
            S_HDR0: begin
                w_pop = ~bus.fifo_empty;
                if (w_pop) begin
                    w_state_nxt = S_HDR1;
                end
            end

            S_HDR1: begin
                w_pop = ~bus.fifo_empty;
                if (w_pop) begin
                    w_state_nxt = S_CMD;
                end
            end

            S_CMD: begin
                // Held until accepted; nothing else moves meanwhile.
                w_cmd_valid = 1'b1;
                if (bus.cmd_ready) begin
                    if (r_cmd_we) begin
                        w_state_nxt = S_WDATA;
                    end else begin
                        w_req_done  = 1'b1;
                        w_state_nxt = S_HDR0;
                    end
                end
            end

            S_WDATA: begin
                // The FIFO head is the beat itself, so a beat transfer and a
                // pop are the same event.
                w_wdata_valid = ~bus.fifo_empty;
                w_wdata_last  = (r_beat_cnt == 3'd0);
                w_pop         = ~bus.fifo_empty & bus.wdata_ready;
                if (w_pop && w_wdata_last) begin
                    w_req_done  = 1'b1;
                    w_state_nxt = S_HDR0;
                end
            end

            default: begin
                w_state_nxt = S_HDR0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Command fields, beat counter, completion counter and header error.
    // Command fields only change on header pops, so they stay stable from
    // CMD entry through the whole write burst.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= 24'd0;
            r_cmd_len   <= 4'd0;
            r_beat_cnt  <= 3'd0;
            r_req_count <= '0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_hdr_err <= 1'b0;

            if ((r_state == S_HDR0) && w_pop) begin
                r_cmd_we           <= bus.fifo_rd_data[15];
                r_cmd_len          <= {1'b0, bus.fifo_rd_data[14:12]} + 4'd1;
                r_cmd_addr[23:12]  <= bus.fifo_rd_data[11:0];
            end

            if ((r_state == S_HDR1) && w_pop) begin
                r_cmd_addr[11:0] <= bus.fifo_rd_data[11:0];
                // Reserved bits are flagged but otherwise ignored.
                r_hdr_err        <= |bus.fifo_rd_data[15:12];
            end

            if ((r_state == S_CMD) && bus.cmd_ready && r_cmd_we) begin
                r_beat_cnt <= 3'(r_cmd_len - 4'd1);
            end

            // Stop at zero on the last beat so the counter idles at 0.
            if ((r_state == S_WDATA) && w_pop && !w_wdata_last) begin
                r_beat_cnt <= r_beat_cnt - 3'd1;
            end

            if (w_req_done) begin
                r_req_count <= r_req_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The pop strobe is also masked by rst so that nothing is
    // consumed while the block is held in reset.
    // ------------------------------------------------------------------------
    assign bus.fifo_rd_enable = w_pop & ~rst;
    assign bus.cmd_valid      = w_cmd_valid;
    assign bus.cmd_we         = r_cmd_we;
    assign bus.cmd_addr       = r_cmd_addr;
    assign bus.cmd_len        = r_cmd_len;
    assign bus.wdata_valid    = w_wdata_valid;
    assign bus.wdata          = bus.fifo_rd_data;
    assign bus.wdata_last     = w_wdata_last;
    assign bus.hdr_err        = r_hdr_err;
    assign bus.req_count      = r_req_count;

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_req_fetch
//  Description : Self-checking bench for sdram_req_fetch. A cycle table of
//                directed vectors covers read, write burst and header error
//                paths; hand-written sequences drive a small FIFO model for
//                backpressure, sparse FIFO, reset mid-burst and counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_req_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_req_fetch_if #(.DWIDTH(16), .CNT_W(16)) bus ();
    sdram_req_fetch_if #(.DWIDTH(16), .CNT_W(3))  bus2 ();

    sdram_req_fetch #(.DWIDTH(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Second instance: FIFO always full of zero words (read, len 1), engine
    // always ready, narrow counter so the wrap is reached quickly.
    sdram_req_fetch #(.DWIDTH(16), .CNT_W(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );
    assign bus2.fifo_empty   = 1'b0;
    assign bus2.fifo_rd_data = 16'h0000;
    assign bus2.cmd_ready    = 1'b1;
    assign bus2.wdata_ready  = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- vector table ----------------
    typedef struct {
        logic        empty;
        logic [15:0] data;
        logic        cr;
        logic        wr;
        logic        rd;
        logic        cv;
        logic        we;
        logic [23:0] addr;
        logic [3:0]  len;
        logic        wv;
        logic        wl;
        logic        herr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [0:18];

    // ---------------- FIFO model / monitor state ----------------
    logic [15:0] q[$];
    int          gap;
    int          gap_len;
    bit          pop_now;
    bit          hold_pending;
    logic        hold_we;
    logic [23:0] hold_addr;
    logic [3:0]  hold_len;
    int          n_cmds;
    logic        cap_we;
    logic [23:0] cap_addr;
    logic [3:0]  cap_len;
    logic [16:0] beats[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty   = (q.size() == 0) || (gap != 0);
        bus.fifo_rd_data = (q.size() != 0) ? q[0] : 16'h0000;
    endtask

    task automatic monitor();
        n_checks++;
        if (bus.fifo_rd_enable && bus.fifo_empty) begin
            n_errors++;
            $display("FAIL underflow_pop: fifo_rd_enable=1 while fifo_empty=1 (t=%0t)", $time);
        end
        n_checks++;
        if (bus.cmd_valid && bus.wdata_valid) begin
            n_errors++;
            $display("FAIL valid_overlap: cmd_valid=1 and wdata_valid=1 (t=%0t)", $time);
        end
        if (hold_pending) begin
            n_checks++;
            if (!bus.cmd_valid || bus.cmd_we !== hold_we ||
                bus.cmd_addr !== hold_addr || bus.cmd_len !== hold_len) begin
                n_errors++;
                $display("FAIL cmd_hold: got v=%0b we=%0b addr=0x%0h len=%0d expected v=1 we=%0b addr=0x%0h len=%0d",
                         bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_len,
                         hold_we, hold_addr, hold_len);
            end
        end
        hold_pending = bus.cmd_valid && !bus.cmd_ready;
        hold_we      = bus.cmd_we;
        hold_addr    = bus.cmd_addr;
        hold_len     = bus.cmd_len;
        if (bus.cmd_valid && bus.cmd_ready) begin
            n_cmds++;
            cap_we   = bus.cmd_we;
            cap_addr = bus.cmd_addr;
            cap_len  = bus.cmd_len;
        end
        if (bus.wdata_valid && bus.wdata_ready) begin
            beats.push_back({bus.wdata_last, bus.wdata});
        end
        pop_now = bus.fifo_rd_enable;
    endtask

    // One clock of the model-driven bench: called and returning at negedge.
    task automatic tick();
        drive_fifo();
        #1;
        monitor();
        @(posedge clk);
        #1;
        if (pop_now) begin
            if (q.size() != 0) void'(q.pop_front());
            gap = gap_len;
        end else if (gap > 0) begin
            gap--;
        end
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
        beats.delete();
        gap          = 0;
        gap_len      = 0;
        n_cmds       = 0;
        hold_pending = 0;
        pop_now      = 0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = 16'h0000;
        bus.cmd_ready    = 1'b0;
        bus.wdata_ready  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rd_en"},  32'(bus.fifo_rd_enable), 32'd0);
        chk({tag, " cv"},     32'(bus.cmd_valid),      32'd0);
        chk({tag, " wv"},     32'(bus.wdata_valid),    32'd0);
        chk({tag, " wl"},     32'(bus.wdata_last),     32'd0);
        chk({tag, " herr"},   32'(bus.hdr_err),        32'd0);
        chk({tag, " we"},     32'(bus.cmd_we),         32'd0);
        chk({tag, " addr"},   32'(bus.cmd_addr),       32'd0);
        chk({tag, " len"},    32'(bus.cmd_len),        32'd0);
        chk({tag, " count"},  32'(bus.req_count),      32'd0);
    endtask

    task automatic chk_beats(input string tag, input logic [16:0] exp[$]);
        chk({tag, " beat count"}, 32'(beats.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
            chk($sformatf("%s beat%0d", tag, i), 32'(beats[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          done;
        logic [16:0] exp_b[$];

        //                empty data      cr   wr   rd   cv   we   addr        len  wv   wl   herr cnt
        vecs[0]  = '{1'b0, 16'h2ABC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 16'h0DEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'hABC000, 4'd3, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 4'd3, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 4'd3, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 16'hB123, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'hABCDEF, 4'd3, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 16'h0456, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h123DEF, 4'd4, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h123456, 4'd4, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b0, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 16'h2222, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 16'h3333, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 16'h4444, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b1, 1'b1, 1'b0, 16'd1};
        vecs[12] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 4'd4, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[14] = '{1'b0, 16'hF001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h001456, 4'd1, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[15] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h001001, 4'd1, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[16] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h001001, 4'd1, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[17] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h001001, 4'd1, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[18] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h001001, 4'd1, 1'b0, 1'b0, 1'b0, 16'd3};

        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = 16'h0000;
        bus.cmd_ready    = 1'b0;
        bus.wdata_ready  = 1'b0;
        gap = 0; gap_len = 0; n_cmds = 0; hold_pending = 0; pop_now = 0;

        // ---- reset state while rst is held ----
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);

        // ---- counter wrap on the 3-bit instance: one read per 3 cycles ----
        do_reset();
        repeat (3) @(negedge clk);
        chk("wrap count after 1 req", 32'(bus2.req_count), 32'd1);
        repeat (18) @(negedge clk);
        chk("wrap count after 7 reqs", 32'(bus2.req_count), 32'd7);
        repeat (3) @(negedge clk);
        chk("wrap count after 8 reqs", 32'(bus2.req_count), 32'd0);

        // ---- cycle table: read, write burst 4, header error ----
        do_reset();
        for (int i = 0; i < 19; i++) begin
            bus.fifo_empty   = vecs[i].empty;
            bus.fifo_rd_data = vecs[i].data;
            bus.cmd_ready    = vecs[i].cr;
            bus.wdata_ready  = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d rd_en", i), 32'(bus.fifo_rd_enable), 32'(vecs[i].rd));
            chk($sformatf("vec%0d cv", i),    32'(bus.cmd_valid),      32'(vecs[i].cv));
            chk($sformatf("vec%0d we", i),    32'(bus.cmd_we),         32'(vecs[i].we));
            chk($sformatf("vec%0d addr", i),  32'(bus.cmd_addr),       32'(vecs[i].addr));
            chk($sformatf("vec%0d len", i),   32'(bus.cmd_len),        32'(vecs[i].len));
            chk($sformatf("vec%0d wv", i),    32'(bus.wdata_valid),    32'(vecs[i].wv));
            chk($sformatf("vec%0d wl", i),    32'(bus.wdata_last),     32'(vecs[i].wl));
            chk($sformatf("vec%0d herr", i),  32'(bus.hdr_err),        32'(vecs[i].herr));
            chk($sformatf("vec%0d count", i), 32'(bus.req_count),      32'(vecs[i].cnt));
            if (vecs[i].wv) begin
                chk($sformatf("vec%0d wdata", i), 32'(bus.wdata), 32'(vecs[i].data));
            end
            @(negedge clk);
        end

        // ---- backpressure: cmd_ready low 10 cycles, toggling wdata_ready ----
        do_reset();
        q = '{16'hB123, 16'h0456, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            if (bus.cmd_valid) done = 1;
        end
        chk("bp cmd_valid reached", 32'(done), 32'd1);
        repeat (10) tick();
        chk("bp cmd_valid held", 32'(bus.cmd_valid), 32'd1);
        chk("bp no pops while held", 32'(q.size()), 32'd4);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            bus.wdata_ready = (k % 2 == 0);
            tick();
            if (bus.req_count == 16'd1) done = 1;
        end
        chk("bp request completed", 32'(done), 32'd1);
        chk("bp cmds", 32'(n_cmds), 32'd1);
        chk("bp we", 32'(cap_we), 32'd1);
        chk("bp addr", 32'(cap_addr), 32'h123456);
        chk("bp len", 32'(cap_len), 32'd4);
        exp_b = '{17'h01111, 17'h02222, 17'h03333, 17'h14444};
        chk_beats("bp", exp_b);
        chk("bp fifo drained", 32'(q.size()), 32'd0);

        // ---- sparse FIFO: 5 empty cycles before every word, write len 2 ----
        do_reset();
        q = '{16'h9ABC, 16'h0DEF, 16'h5555, 16'h6666};
        gap_len = 5;
        gap     = 5;
        bus.cmd_ready   = 1'b1;
        bus.wdata_ready = 1'b1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick();
            if (bus.req_count == 16'd1) done = 1;
        end
        chk("sparse request completed", 32'(done), 32'd1);
        chk("sparse cmds", 32'(n_cmds), 32'd1);
        chk("sparse we", 32'(cap_we), 32'd1);
        chk("sparse addr", 32'(cap_addr), 32'hABCDEF);
        chk("sparse len", 32'(cap_len), 32'd2);
        exp_b = '{17'h05555, 17'h16666};
        chk_beats("sparse", exp_b);

        // ---- reset in WDATA after beat 1 of 4 ----
        do_reset();
        q = '{16'hB123, 16'h0456, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        bus.cmd_ready   = 1'b1;
        bus.wdata_ready = 1'b1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (beats.size() == 1) done = 1;
        end
        chk("rst-mid first beat seen", 32'(done), 32'd1);
        chk("rst-mid in burst", 32'(bus.wdata_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst-mid async");
        @(negedge clk);
        #1;
        chk_reset_outputs("rst-mid next cycle");
        q.delete();
        beats.delete();
        n_cmds = 0;
        hold_pending = 0;
        gap = 0; gap_len = 0;
        drive_fifo();
        rst = 1'b0;
        @(negedge clk);
        tick();
        chk("rst-mid idle cv", 32'(bus.cmd_valid), 32'd0);
        chk("rst-mid idle wv", 32'(bus.wdata_valid), 32'd0);
        q = '{16'h2ABC, 16'h0DEF};
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (bus.req_count == 16'd1) done = 1;
        end
        chk("rst-mid restart completed", 32'(done), 32'd1);
        chk("rst-mid restart we", 32'(cap_we), 32'd0);
        chk("rst-mid restart addr", 32'(cap_addr), 32'hABCDEF);
        chk("rst-mid restart len", 32'(cap_len), 32'd3);
        chk("rst-mid restart no beats", 32'(beats.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
